dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 32, meaning phase accumulator and tuning word width.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning ROM address width, taken from acc[ACC_W-1 -: ADDR_W].
REQ-003 SHALL have parameter DWELL_W, default 24, meaning dwell counter width.
REQ-004 SHALL have port sys_clk, input, 1, single clock for all logic.
REQ-005 SHALL have port sys_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_wr, input, 1, config write strobe, one word per cycle.
REQ-007 SHALL have port cfg_addr, input, 3, register select: 0 FSTART, 1 FSTOP, 2 FSTEP, 3 DWELL, 4 CTRL; 5-7 ignored.
REQ-008 SHALL have port cfg_wdata, input, 32, write data, truncated to the register width.
REQ-009 SHALL have port start, input, 1, sweep start pulse.
REQ-010 SHALL have port stop, input, 1, sweep abort pulse.
REQ-011 SHALL have port ftw, output, ACC_W, current frequency tuning word (registered).
REQ-012 SHALL have port rom_addr, output, ADDR_W, registered ROM address.
REQ-013 SHALL have port wave_sel, output, 2, CTRL[1:0], selects waveform table.
REQ-014 SHALL have port busy, output, 1, high while in RUN.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at single-sweep completion.

Function
REQ-016 SHALL define CTRL as: [1:0] wave_sel; [2] cont (restart sweep forever); [3] bidir (up then down).
REQ-017 SHALL ignore writes to FSTART/FSTOP/FSTEP/DWELL while busy=1; CTRL writes SHALL take effect the next cycle in any state.
REQ-018 SHALL treat DWELL=0 as 1 and FSTEP=0 as 1.
REQ-019 SHALL implement states IDLE and RUN only; done SHALL be asserted on the RUN->IDLE completion transition.
REQ-020 IDLE + start (stop=0): next cycle state=RUN, busy=1, ftw=FSTART, dwell_cnt=0, dir=up.
REQ-021 In RUN, dwell_cnt SHALL increment each cycle; at dwell_cnt=DWELL-1 it SHALL clear and a step event SHALL occur.
REQ-022 Up step: sum=ftw+FSTEP computed ACC_W+1 bits wide; if sum>=FSTOP then ftw=FSTOP (end reached), else ftw=sum.
REQ-023 Down step (bidir only): if ftw<FSTART+FSTEP then ftw=FSTART (start reached), else ftw=ftw-FSTEP.
REQ-024 A step event with ftw already at FSTOP (dir up) SHALL: bidir -> dir=down and apply down step; not bidir and cont -> ftw=FSTART; neither -> RUN->IDLE, done=1 for one cycle, ftw holds FSTOP.
REQ-025 A step event with ftw at FSTART and dir=down SHALL: cont -> dir=up and apply up step; else RUN->IDLE, done pulse, ftw holds FSTART.
REQ-026 If FSTOP<=FSTART at start, ftw SHALL load FSTART and never change; after one dwell period, single mode ends with done; cont/bidir continue holding FSTART.
REQ-027 stop in RUN: next cycle IDLE, busy=0, no done, ftw holds last value; stop wins over a simultaneous start or step event.
REQ-028 start while busy SHALL be ignored.
REQ-029 Phase accumulator SHALL add ftw every cycle in all states, wrapping modulo 2^ACC_W; rom_addr SHALL be registered accumulator MSBs, one cycle behind acc.
REQ-030 A new ftw value SHALL first affect the accumulator on the cycle after ftw changes.

Reset
REQ-031 On sys_rst_n=0, immediately: state=IDLE, ftw=0, acc=0, rom_addr=0, busy=0, done=0, dwell_cnt=0, dir=up, FSTART=0, FSTOP=0, FSTEP=1, DWELL=1, CTRL=0.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; after release the block SHALL sit in IDLE until start.

Verification
REQ-033 FSTART=100, FSTOP=130, FSTEP=10, DWELL=3, CTRL=0, start -> ftw 100,110,120,130 each held 3 cycles; done pulses one cycle as ftw stays 130; busy falls on that cycle.
REQ-034 Same config with FSTEP=25 -> ftw 100,125,130 (clamped); done after 3 cycles at 130.
REQ-035 CTRL bidir=1, cont=1, FSTART=0, FSTOP=20, FSTEP=10, DWELL=1 -> ftw 0,10,20,20? No: 0,10,20,10,0,10,20,... repeating, done never asserted, busy stays 1.
REQ-036 stop issued mid-sweep at ftw=110 together with start -> IDLE next cycle, ftw=110, no done; write FSTART=7 while busy earlier is verified ignored.
REQ-037 ftw=2^18 held, acc from 0 -> rom_addr increments by 1 per cycle, wraps 16383->0; sys_rst_n pulsed low mid-sweep -> all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS: steps a tuning word between FSTART and FSTOP
// with a programmable dwell, and drives the phase accumulator that addresses the wave ROM.
module dds_sweep_ctrl #(
    parameter int ACC_W   = 32,
    parameter int ADDR_W  = 14,
    parameter int DWELL_W = 24
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic              start,
    input  logic              stop,
    output logic [ACC_W-1:0]  ftw,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        wave_sel,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] A_FSTART = 3'd0;
    localparam logic [2:0] A_FSTOP  = 3'd1;
    localparam logic [2:0] A_FSTEP  = 3'd2;
    localparam logic [2:0] A_DWELL  = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   fstart, fstop, fstep;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         ctrl;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   ftw_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
    logic               dir_down, dir_down_nxt;
    logic               done_nxt;

    logic [ACC_W-1:0]   step_eff;
    logic [DWELL_W-1:0] dwell_last;
    logic [ACC_W:0]     up_sum, down_floor;
    logic [ACC_W-1:0]   up_val, down_val;
    logic               cont, bidir, step_evt;

    assign cont     = ctrl[2];
    assign bidir    = ctrl[3];
    assign wave_sel = ctrl[1:0];
    assign busy     = (state == RUN);

    // Sweep limits are frozen during a run; CTRL stays live so mode bits can change mid-sweep.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fstart <= '0;
            fstop  <= '0;
            fstep  <= ACC_W'(1);
            dwell  <= DWELL_W'(1);
            ctrl   <= '0;
        end else if (cfg_wr) begin
            if (cfg_addr == A_CTRL) begin
                ctrl <= cfg_wdata[3:0];
            end else if (state != RUN) begin
                case (cfg_addr)
                    A_FSTART: fstart <= ACC_W'(cfg_wdata);
                    A_FSTOP:  fstop  <= ACC_W'(cfg_wdata);
                    A_FSTEP:  fstep  <= ACC_W'(cfg_wdata);
                    A_DWELL:  dwell  <= DWELL_W'(cfg_wdata);
                    default:  ;
                endcase
            end
        end
    end

    // Zero step/dwell behave as one; sums are one bit wider so the clamp never sees a wrap.
    always_comb begin
        step_eff   = (fstep == '0) ? ACC_W'(1) : fstep;
        dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        step_evt   = (dwell_cnt >= dwell_last);
        up_sum     = {1'b0, ftw} + {1'b0, step_eff};
        up_val     = (up_sum >= {1'b0, fstop}) ? fstop : up_sum[ACC_W-1:0];
        down_floor = {1'b0, fstart} + {1'b0, step_eff};
        down_val   = ({1'b0, ftw} < down_floor) ? fstart : ftw - step_eff;
    end

    always_comb begin
        state_nxt     = state;
        ftw_nxt       = ftw;
        dwell_cnt_nxt = dwell_cnt;
        dir_down_nxt  = dir_down;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt     = RUN;
                    ftw_nxt       = fstart;
                    dwell_cnt_nxt = '0;
                    dir_down_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt     = IDLE;
                    dwell_cnt_nxt = '0;
                end else if (!step_evt) begin
                    dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
                end else begin
                    dwell_cnt_nxt = '0;
                    // An empty range pins ftw at FSTART; only single mode terminates.
                    if (fstop <= fstart) begin
                        if (!cont && !bidir) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else if (!dir_down) begin
                        if (ftw >= fstop) begin
                            if (bidir) begin
                                dir_down_nxt = 1'b1;
                                ftw_nxt      = down_val;
                            end else if (cont) begin
                                ftw_nxt = fstart;
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            ftw_nxt = up_val;
                        end
                    end else begin
                        if (ftw <= fstart) begin
                            if (cont) begin
                                dir_down_nxt = 1'b0;
                                ftw_nxt      = up_val;
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            ftw_nxt = down_val;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            ftw       <= '0;
            dwell_cnt <= '0;
            dir_down  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ftw       <= ftw_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            dir_down  <= dir_down_nxt;
            done      <= done_nxt;
        end
    end

    // The accumulator reads the registered ftw, so a new tuning word lands one cycle later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc      <= '0;
            rom_addr <= '0;
        end else begin
            acc      <= acc + ftw;
            rom_addr <= acc[ACC_W-1 -: ADDR_W];
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl: hand-computed sweep sequences, register
// locking, stop/reset behaviour and ROM address progression.
module tb_dds_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] ftw;
    logic [13:0] rom_addr;
    logic [1:0]  wave_sel;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    dds_sweep_ctrl #(.ACC_W(32), .ADDR_W(14), .DWELL_W(24)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .stop      (stop),
        .ftw       (ftw),
        .rom_addr  (rom_addr),
        .wave_sel  (wave_sel),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({ftw, rom_addr, wave_sel, busy, done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ftw=%0d rom=%0d ws=%0d busy=%b done=%b, expected all 0",
                     ftw, rom_addr, wave_sel, busy, done);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        // Default FSTART=FSTOP=0, DWELL=1: one dwell at 0 then done.
        pulse_start();
        checks++;
        if ({busy, done, ftw} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_default_run: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=0",
                     busy, done, ftw);
        end
        tick();
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_default_done: got busy=%b done=%b ftw=%0d, expected busy=0 done=1 ftw=0",
                     busy, done, ftw);
        end
        tick();
    endtask

    task automatic test_basic_sweep;
        int exp_ftw [12] = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};
        cfg_write(3'd0, 32'd100);
        cfg_write(3'd1, 32'd130);
        cfg_write(3'd2, 32'd10);
        cfg_write(3'd3, 32'd3);
        cfg_write(3'd4, 32'd0);
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({busy, done, ftw} !== {1'b1, 1'b0, 32'(exp_ftw[i])}) begin
                errors++;
                $display("[TB] FAIL basic_sweep[%0d]: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=%0d",
                         i, busy, done, ftw, exp_ftw[i]);
            end
            tick();
        end
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b1, 32'd130}) begin
            errors++;
            $display("[TB] FAIL basic_done: got busy=%b done=%b ftw=%0d, expected busy=0 done=1 ftw=130",
                     busy, done, ftw);
        end
        tick();
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b0, 32'd130}) begin
            errors++;
            $display("[TB] FAIL basic_after: got busy=%b done=%b ftw=%0d, expected busy=0 done=0 ftw=130",
                     busy, done, ftw);
        end
    endtask

    task automatic test_clamp;
        int exp_ftw [9] = '{100, 100, 100, 125, 125, 125, 130, 130, 130};
        cfg_write(3'd2, 32'd25);
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({busy, done, ftw} !== {1'b1, 1'b0, 32'(exp_ftw[i])}) begin
                errors++;
                $display("[TB] FAIL clamp_sweep[%0d]: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=%0d",
                         i, busy, done, ftw, exp_ftw[i]);
            end
            // A start while busy must not restart the sweep.
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b1, 32'd130}) begin
            errors++;
            $display("[TB] FAIL clamp_done: got busy=%b done=%b ftw=%0d, expected busy=0 done=1 ftw=130",
                     busy, done, ftw);
        end
        tick();
    endtask

    task automatic test_bidir_cont;
        int pat [4] = '{0, 10, 20, 10};
        cfg_write(3'd0, 32'd0);
        cfg_write(3'd1, 32'd20);
        cfg_write(3'd2, 32'd10);
        cfg_write(3'd3, 32'd1);
        cfg_write(3'd4, 32'd12);
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({busy, done, ftw} !== {1'b1, 1'b0, 32'(pat[i % 4])}) begin
                errors++;
                $display("[TB] FAIL bidir_sweep[%0d]: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=%0d",
                         i, busy, done, ftw, pat[i % 4]);
            end
            if (i == 11) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b0, 32'd10}) begin
            errors++;
            $display("[TB] FAIL bidir_stop: got busy=%b done=%b ftw=%0d, expected busy=0 done=0 ftw=10",
                     busy, done, ftw);
        end
    endtask

    task automatic test_stop_and_lock;
        cfg_write(3'd0, 32'd100);
        cfg_write(3'd1, 32'd130);
        cfg_write(3'd2, 32'd10);
        cfg_write(3'd3, 32'd3);
        cfg_write(3'd4, 32'd0);
        pulse_start();
        checks++;
        if ({busy, ftw} !== {1'b1, 32'd100}) begin
            errors++;
            $display("[TB] FAIL lock_first: got busy=%b ftw=%0d, expected busy=1 ftw=100", busy, ftw);
        end
        cfg_write(3'd0, 32'd7);
        cfg_write(3'd4, 32'd2);
        checks++;
        if ({busy, wave_sel, ftw} !== {1'b1, 2'd2, 32'd100}) begin
            errors++;
            $display("[TB] FAIL ctrl_live: got busy=%b ws=%0d ftw=%0d, expected busy=1 ws=2 ftw=100",
                     busy, wave_sel, ftw);
        end
        tick();
        checks++;
        if (ftw !== 32'd110) begin
            errors++;
            $display("[TB] FAIL lock_step: got ftw=%0d, expected 110", ftw);
        end
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b0, 32'd110}) begin
            errors++;
            $display("[TB] FAIL stop_wins: got busy=%b done=%b ftw=%0d, expected busy=0 done=0 ftw=110",
                     busy, done, ftw);
        end
        tick();
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b0, 32'd110}) begin
            errors++;
            $display("[TB] FAIL stop_hold: got busy=%b done=%b ftw=%0d, expected busy=0 done=0 ftw=110",
                     busy, done, ftw);
        end
        pulse_start();
        checks++;
        if ({busy, ftw} !== {1'b1, 32'd100}) begin
            errors++;
            $display("[TB] FAIL fstart_locked: got busy=%b ftw=%0d, expected busy=1 ftw=100", busy, ftw);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cfg_write(3'd4, 32'd0);
    endtask

    task automatic test_degenerate;
        cfg_write(3'd0, 32'd50);
        cfg_write(3'd1, 32'd50);
        cfg_write(3'd2, 32'd10);
        cfg_write(3'd3, 32'd2);
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy, done, ftw} !== {1'b1, 1'b0, 32'd50}) begin
                errors++;
                $display("[TB] FAIL degen_single[%0d]: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=50",
                         i, busy, done, ftw);
            end
            tick();
        end
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b1, 32'd50}) begin
            errors++;
            $display("[TB] FAIL degen_done: got busy=%b done=%b ftw=%0d, expected busy=0 done=1 ftw=50",
                     busy, done, ftw);
        end
        cfg_write(3'd4, 32'd4);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({busy, done, ftw} !== {1'b1, 1'b0, 32'd50}) begin
                errors++;
                $display("[TB] FAIL degen_cont[%0d]: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=50",
                         i, busy, done, ftw);
            end
            if (i == 5) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        cfg_write(3'd4, 32'd0);
    endtask

    task automatic test_zero_step_dwell;
        cfg_write(3'd0, 32'd0);
        cfg_write(3'd1, 32'd3);
        cfg_write(3'd2, 32'd0);
        cfg_write(3'd3, 32'd0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done, ftw} !== {1'b1, 1'b0, 32'(i)}) begin
                errors++;
                $display("[TB] FAIL zero_cfg[%0d]: got busy=%b done=%b ftw=%0d, expected busy=1 done=0 ftw=%0d",
                         i, busy, done, ftw, i);
            end
            tick();
        end
        checks++;
        if ({busy, done, ftw} !== {1'b0, 1'b1, 32'd3}) begin
            errors++;
            $display("[TB] FAIL zero_cfg_done: got busy=%b done=%b ftw=%0d, expected busy=0 done=1 ftw=3",
                     busy, done, ftw);
        end
        tick();
    endtask

    task automatic test_rom_addr;
        int exp_addr;
        do_reset();
        cfg_write(3'd0, 32'h0004_0000);
        cfg_write(3'd1, 32'h0004_0000);
        cfg_write(3'd3, 32'd1);
        cfg_write(3'd4, 32'd4);
        pulse_start();
        checks++;
        if ({busy, ftw} !== {1'b1, 32'h0004_0000}) begin
            errors++;
            $display("[TB] FAIL rom_ftw: got busy=%b ftw=%0h, expected busy=1 ftw=40000", busy, ftw);
        end
        for (int k = 0; k <= 16400; k++) begin
            exp_addr = (k == 0) ? 0 : ((k - 1) % 16384);
            checks++;
            if (rom_addr !== 14'(exp_addr)) begin
                errors++;
                $display("[TB] FAIL rom_addr[%0d]: got %0d, expected %0d", k, rom_addr, exp_addr);
            end
            tick();
        end
    endtask

    task automatic test_async_reset;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({ftw, rom_addr, wave_sel, busy, done} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got ftw=%0d rom=%0d ws=%0d busy=%b done=%b, expected all 0",
                     ftw, rom_addr, wave_sel, busy, done);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({busy, done, ftw, rom_addr} !== '0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle[%0d]: got busy=%b done=%b ftw=%0d rom=%0d, expected all 0",
                         i, busy, done, ftw, rom_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_clamp();
        test_bidir_cont();
        test_stop_and_lock();
        test_degenerate();
        test_zero_step_dwell();
        test_rom_addr();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
